// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-byte transmit queue feeding uart_tx via tx_start/tx_end.
// Ports: wr_en/wr_data push, flush, ovf_clr; full/empty/level/overflow status; irq_tx_done; tx_* handshake.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              irq_tx_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_end
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic [1:0]        state;
  logic              drop_irq;
  logic              push;
  logic              pop;
  logic              reject;
  logic              in_wait;

  assign in_wait  = (state == WAIT);
  assign push     = wr_en & ~full & ~flush;
  assign reject   = wr_en & full & ~flush;
  assign pop      = (state == IDLE) & ~empty & ~tx_busy & ~flush;
  assign level    = count;
  assign tx_start = (state == LAUNCH);

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CNT_MAX);
      empty <= (count_nxt == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (reject)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            state   <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (tx_end)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A byte in flight when the queue was flushed must not report completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_irq <= 1'b0;
    else if (flush && state != IDLE)
      drop_irq <= 1'b1;
    else if (state == IDLE)
      drop_irq <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      irq_tx_done <= 1'b0;
    else
      irq_tx_done <= in_wait & tx_end & (count == '0)
                   & ~push & ~flush & ~drop_irq;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit buffer placed between uart_ctrl and the uart_tx serialiser. It holds up to DEPTH bytes written by the control side and feeds them one at a time to uart_tx through the existing tx_start / tx_data / tx_busy / tx_end handshake. Software can queue a burst without polling per byte. A completion interrupt fires when the queue has drained and the last byte has finished on the line.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two.
ADDR_W, 4, log2(DEPTH); pointer width.
DATA_W, 8, byte width; must match `ByteDataBus.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-low reset.
wr_en  in  1  push request from uart_ctrl, one byte per cycle.
wr_data  in  DATA_W  byte to push.
flush  in  1  discard all queued bytes.
ovf_clr  in  1  clear the sticky overflow flag.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
level  out  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky; set when a push is rejected.
irq_tx_done  out  1  one-cycle pulse when the queue has drained and the last byte has ended.
tx_start  out  1  one-cycle start strobe to uart_tx.
tx_data  out  DATA_W  byte presented to uart_tx; held stable until the next launch.
tx_busy  in  1  uart_tx is shifting.
tx_end  in  1  one-cycle pulse from uart_tx when a frame completes.

Behaviour:
- Reset (rst low, asynchronous):
  - pointers, count and FSM cleared; FSM enters IDLE.
  - full=0, empty=1, level=0, overflow=0, irq_tx_done=0, tx_start=0, tx_data=0.
- Storage: circular RAM of DEPTH x DATA_W; wr_ptr and rd_ptr are ADDR_W bits and wrap from DEPTH-1 to 0. A separate count of ADDR_W+1 bits drives full, empty and level. All status outputs are registered from count.
- Push: accepted iff wr_en=1, full=0 and flush=0. Entry is written at wr_ptr, wr_ptr increments, count increments. The new level is visible the next cycle.
- Rejected push (wr_en=1, full=1, flush=0): data dropped, no state change, overflow set next cycle. overflow stays set until ovf_clr=1. If set and clear occur in the same cycle, set wins.
- Flush: pointers and count go to 0 next cycle. A same-cycle wr_en is dropped silently, without setting overflow. A byte already launched (LAUNCH or WAIT) is not aborted.
- Transmit FSM, states IDLE, LAUNCH, WAIT:
  - IDLE: if empty=0, tx_busy=0 and flush=0, pop the head into tx_data, advance rd_ptr, decrement count, and go to LAUNCH.
  - LAUNCH: tx_start=1 for exactly this cycle; go to WAIT.
  - WAIT: tx_start=0; on tx_end=1 go to IDLE.
- Latency: a push into an empty idle FIFO at cycle N produces level=1 at N+1 and tx_start high at N+2, with tx_data valid at N+2.
- Back-to-back bytes: the next tx_start rises 2 cycles after tx_end, provided tx_busy=0 by then.
- Simultaneous push and pop in IDLE: both take effect and count is unchanged. When full, a pop does not make room for a same-cycle push; that push is rejected and overflow is set.
- irq_tx_done: pulses for one cycle, the cycle after tx_end is seen in WAIT, if count was 0 in the tx_end cycle and no push was accepted in that cycle. It does not fire on flush alone.
- tx_data changes only on a pop and is never 'x' after reset.

Test Plan:
1. Reset, push 0x55 at cycle 10 -> level=1 at 11, tx_start high for exactly cycle 12 with tx_data=0x55. Model tx_end at cycle 30 -> irq_tx_done high at cycle 31 only, empty=1.
2. Push 0x01..0x10 (16 bytes) back-to-back with uart_tx held busy -> full=1, level=16. A 17th push of 0xAA sets overflow and later bytes are unaffected. ovf_clr clears overflow. Release the model -> bytes emerge 0x01..0x10 in order with wrap-around correct, then one irq_tx_done.
3. With the FIFO full and the FSM in IDLE, assert wr_en in the pop cycle -> pop occurs, push rejected, overflow=1, level=15.
4. Queue 5 bytes, flush while byte 1 is in WAIT with wr_en asserted -> level=0 next cycle, overflow stays 0, byte 1 still completes. No further tx_start and no irq_tx_done.
5. Push a byte in the same cycle as tx_end of the last byte -> irq_tx_done suppressed, and the new byte's tx_start follows 2 cycles later.
6. Assert rst low mid-transfer (state WAIT, level=3) -> all outputs return to reset values immediately, without waiting for a clock edge. After release, the FIFO is empty and no tx_start is issued.
